// File: rtl/sorter_pkg.sv
// Shared types and helpers for the run sorter slice.
package sorter_pkg;

    typedef enum logic [1:0] {FILL, SORT, DRAIN} run_state_t;

    function automatic int unsigned pn(input int unsigned lp);
        return 32'd1 << lp;
    endfunction

endpackage

// File: rtl/run_sorter_bn.sv
// BN: combinational bitonic sorting network over 2**LP words of DW bits.
// DESC=0 sorts ascending with word 0 smallest.
module BN
    import sorter_pkg::*;
#(
    parameter int unsigned LP   = 3,
    parameter int unsigned DW   = 8,
    parameter bit          DESC = 1'b0
) (
    input  logic [pn(LP)*DW-1:0] data_in,
    output logic [pn(LP)*DW-1:0] data_out
);
    localparam int unsigned PN = pn(LP);

    logic [DW-1:0] v [PN];
    logic [DW-1:0] t;
    bit            up;

    // Classic iterative bitonic network: each k-stage merges bitonic blocks of size k.
    always_comb begin
        t  = '0;
        up = 1'b0;
        for (int unsigned i = 0; i < PN; i++) begin
            v[i] = data_in[i*DW +: DW];
        end
        for (int unsigned k = 2; k <= PN; k = k << 1) begin
            for (int unsigned j = k >> 1; j > 0; j = j >> 1) begin
                for (int unsigned i = 0; i < PN; i++) begin
                    if ((i ^ j) > i) begin
                        up = (((i & k) == 0) != DESC);
                        if (up ? (v[i] > v[i ^ j]) : (v[i] < v[i ^ j])) begin
                            t         = v[i];
                            v[i]      = v[i ^ j];
                            v[i ^ j]  = t;
                        end
                    end
                end
            end
        end
        for (int unsigned i = 0; i < PN; i++) begin
            data_out[i*DW +: DW] = v[i];
        end
    end

endmodule

// File: rtl/run_sorter.sv
// run_sorter: collects 2**LP words, sorts them with BN, emits an ascending run.
// Optional partial-run flush via `RUN_SORTER_FLUSH_EN (adds flush_i port).
module run_sorter
    import sorter_pkg::*;
#(
    parameter int unsigned LP = 3,
    parameter int unsigned dw = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [dw-1:0] data_i,
    input  logic          req_i,
    output logic          ack_i,
    output logic [dw-1:0] data_o,
    output logic          req_o,
    input  logic          ack_o
`ifdef RUN_SORTER_FLUSH_EN
    ,
    input  logic          flush_i
`endif
);
    localparam int unsigned PN   = pn(LP);
    localparam logic [LP:0] PN_C = (LP+1)'(PN);
    localparam logic [LP:0] ONE  = (LP+1)'(1);

    run_state_t       state;
    logic [LP:0]      wcnt;
    logic [LP:0]      rcnt;
    logic [LP:0]      len;
    logic [LP:0]      k;
    logic [dw-1:0]    ibuf [PN];
    logic [dw-1:0]    sbuf [PN];
    logic [PN*dw-1:0] bn_in;
    logic [PN*dw-1:0] bn_out;
    logic             accept;
    logic             flush_req;

    assign ack_i  = (state == FILL);
    assign req_o  = (state == DRAIN);
    assign data_o = req_o ? sbuf[rcnt[LP-1:0]] : '0;
    assign accept = ack_i & req_i;
    assign k      = wcnt + {{LP{1'b0}}, accept};

`ifdef RUN_SORTER_FLUSH_EN
    assign flush_req = flush_i && (k != '0) && (k < PN_C);
`else
    assign flush_req = 1'b0;
`endif

    always_comb begin
        for (int unsigned i = 0; i < PN; i++) begin
            bn_in[i*dw +: dw] = ibuf[i];
        end
    end

    BN #(.LP(LP), .DW(dw), .DESC(1'b0)) u_bn (
        .data_in  (bn_in),
        .data_out (bn_out)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= FILL;
            wcnt  <= '0;
            rcnt  <= '0;
            len   <= '0;
            for (int unsigned i = 0; i < PN; i++) begin
                ibuf[i] <= '0;
                sbuf[i] <= '0;
            end
        end else begin
            unique case (state)
                FILL: begin
                    if (accept) begin
                        ibuf[wcnt[LP-1:0]] <= data_i;
                        wcnt               <= k;
                    end
                    if (k == PN_C) begin
                        state <= SORT;
                    end else if (flush_req) begin
                        // Pad unused slots with all-ones so they sort to the tail; len stops emission before them.
                        for (int unsigned i = 0; i < PN; i++) begin
                            if ((LP+1)'(i) >= k) ibuf[i] <= '1;
                        end
                        state <= SORT;
                    end
                end
                SORT: begin
                    for (int unsigned i = 0; i < PN; i++) begin
                        sbuf[i] <= bn_out[i*dw +: dw];
                    end
                    rcnt  <= '0;
                    len   <= wcnt;
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (ack_o) begin
                        rcnt <= rcnt + ONE;
                        if (rcnt == len - ONE) begin
                            state <= FILL;
                            wcnt  <= '0;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
